// File: rtl/ram32x4_arb_pkg.sv
// ram32x4_arb_pkg: shared widths and enums for the two-port RAM arbiter.
package ram32x4_arb_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 32;
    typedef enum logic {CLEAR, RUN} state_t;
    typedef enum logic {REQ_A, REQ_B} req_sel_t;
endpackage

// File: rtl/ram32x4_arbiter_if.sv
// ram32x4_arbiter_if: request/grant/read-data bundle for requesters A and B.
interface ram32x4_arbiter_if;
    import ram32x4_arb_pkg::*;
    logic              a_req, b_req;
    logic              a_wren, b_wren;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_din, b_din;
    logic              a_gnt, b_gnt;
    logic              a_rvalid, b_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    modport master (
        output a_req, b_req, a_wren, b_wren, a_addr, b_addr, a_din, b_din,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, rdata, busy
    );
    modport slave (
        input  a_req, b_req, a_wren, b_wren, a_addr, b_addr, a_din, b_din,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, rdata, busy
    );
endinterface

// File: rtl/ram32x4_wrapper.sv
// ram32x4_wrapper: 32x4 single-port RAM, inputs sampled on posedge, read data one cycle later.
module ram32x4_wrapper
    import ram32x4_arb_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout_q <= mem[addr];
    end
    assign dout = dout_q;
endmodule

// File: rtl/ram32x4_arbiter.sv
// ram32x4_arbiter: round-robin A/B arbiter in front of one 32x4 RAM.
// Define RAM32X4_INIT_CLEAR_EN to zero the RAM with a 32-cycle sweep after reset.
module ram32x4_arbiter
    import ram32x4_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    ram32x4_arbiter_if.slave   bus
);
    logic              run, clearing, a_gnt, b_gnt, rv_any;
    logic [ADDR_W-1:0] clr_addr, ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;
    logic              ram_we;
    req_sel_t          ptr_q, ptr_d;
    logic              a_rv_q, a_rv_d, b_rv_q, b_rv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef RAM32X4_INIT_CLEAR_EN
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign run      = state_q == RUN;
    assign clearing = (state_q == CLEAR) && !reset;
    assign clr_addr = cnt_q;
`else
    assign run      = 1'b1;
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif
    always_comb begin
        a_gnt    = run && !reset && bus.a_req && (!bus.b_req || ptr_q == REQ_A);
        b_gnt    = run && !reset && bus.b_req && (!bus.a_req || ptr_q == REQ_B);
        ptr_d    = a_gnt ? REQ_B : (b_gnt ? REQ_A : ptr_q);
        a_rv_d   = a_gnt && !bus.a_wren;
        b_rv_d   = b_gnt && !bus.b_wren;
        ram_we   = clearing || (a_gnt && bus.a_wren) || (b_gnt && bus.b_wren);
        ram_addr = clearing ? clr_addr : (b_gnt ? bus.b_addr : bus.a_addr);
        ram_din  = clearing ? '0 : (b_gnt ? bus.b_din : bus.a_din);
        // a reset arriving while a read is in flight swallows that pulse
        rv_any   = (a_rv_q || b_rv_q) && !reset;
        rdata_d  = rv_any ? ram_dout : rdata_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= REQ_A;
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            a_rv_q  <= a_rv_d;
            b_rv_q  <= b_rv_d;
            rdata_q <= rdata_d;
        end
    end
    ram32x4_wrapper u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );
    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rvalid = a_rv_q && !reset;
    assign bus.b_rvalid = b_rv_q && !reset;
    assign bus.rdata    = rdata_d;
    assign bus.busy     = !run;
endmodule

// File: doc/ram32x4_arbiter.md
RAM32X4_ARBITER -- requirements
Module: ram32x4_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 a_req, b_req  input  1 each  access request from requester A / B.
REQ-004 a_wren, b_wren  input  1 each  1 = write, 0 = read; qualified by the matching req.
REQ-005 a_addr, b_addr  input  5 each  word address 0..31.
REQ-006 a_din, b_din  input  4 each  write data.
REQ-007 a_gnt, b_gnt  output  1 each  combinational grant; the access completes at the posedge where gnt=1.
REQ-008 a_rvalid, b_rvalid  output  1 each  registered; read data for that requester is on rdata this cycle.
REQ-009 rdata  output  4  read data shared by both requesters.
REQ-010 busy  output  1  high while the initial clear sweep runs (CLEAR state).

Function
REQ-011 The block SHALL own one 32x4 single-port RAM and issue at most one access per cycle.
- RAM inputs are registered; data appears one cycle after the address edge.
REQ-012 States SHALL be CLEAR and RUN; the block SHALL enter RUN from CLEAR only after the count-31 write.
REQ-013 In RUN, a grant SHALL be given iff at least one req is high; a_gnt and b_gnt SHALL never both be 1.
REQ-014 Single requester: that requester SHALL be granted in the same cycle, regardless of the priority pointer.
REQ-015 Both requesting: the requester named by the round-robin pointer SHALL be granted.
REQ-016 After any grant, the pointer SHALL name the other requester; with no grant, the pointer SHALL hold.
REQ-017 Granted write: the RAM SHALL store din at addr on the grant edge.
REQ-018 Granted read: the matching rvalid SHALL be 1 exactly one cycle after the grant cycle, with rdata = stored word.
- Read latency is 1.
- rvalid is a single-cycle pulse per grant.
REQ-019 Back-to-back grants SHALL be supported every cycle, with no bubbles.
REQ-020 Read and write to the same address on consecutive cycles: the read SHALL return the value written.
REQ-021 rdata SHALL hold its last value when no rvalid is asserted.
REQ-022 Requests while busy=1 SHALL receive no grant; requesters keep req high until granted.

Reset
REQ-023 Reset SHALL set: a_gnt/b_gnt combinationally 0, a_rvalid=b_rvalid=0, rdata=0, pointer=A, clear counter=0.
REQ-024 Reset SHALL set state=CLEAR (busy=1) when RAM32X4_INIT_CLEAR_EN is defined, else RUN (busy=0).
REQ-025 Reset asserted mid-sweep SHALL restart the sweep at address 0.
REQ-026 Reset asserted in the cycle after a read grant SHALL suppress that rvalid.
REQ-027 RAM contents SHALL NOT be altered by reset itself.

Configuration
REQ-028 The clear sweep SHALL be compiled in only when RAM32X4_INIT_CLEAR_EN is defined.
REQ-029 With the macro defined, behaviour in CLEAR SHALL be:
- write 0000 to address = counter, one address per cycle, counter 0..31;
- busy=1 for 32 cycles;
- no grants.
REQ-030 Without the macro, the block SHALL have no CLEAR state and no clear counter, busy SHALL be tied to 0, and RAM contents after power-up SHALL be undefined.

Structure
REQ-031 Package ram32x4_arb_pkg SHALL hold ADDR_W=5, DATA_W=4, DEPTH=32, the state enum {CLEAR, RUN} and the requester-select enum {REQ_A, REQ_B}.
REQ-032 The RAM SHALL be a single instance of the existing sub-module ram32x4_wrapper.
REQ-033 Arbitration, the address/data mux, the clear counter and the rvalid pipeline SHALL live in ram32x4_arbiter itself.

Verification
REQ-034 Macro on, reset then idle -> busy=1 for exactly 32 cycles, then 0; reads of addresses 0, 17 and 31 return 0000.
REQ-035 A writes 1010 to 00011 alone; next cycle A reads 00011 -> a_gnt=1 both cycles; a_rvalid=1 one cycle later with rdata=1010; b_rvalid stays 0.
REQ-036 A and B both read continuously after reset, pointer=A -> grants alternate A,B,A,B; each rvalid pulses one cycle after its grant.
REQ-037 B writes 1111 to 00010, then A reads 00010 on the next cycle -> a_rvalid with rdata=1111.
REQ-038 Reset pulsed at clear count 10 -> sweep restarts; busy stays 1 for 32 cycles after reset release.
REQ-039 Reset in the cycle after an A read grant -> a_rvalid=0, rdata=0 and pointer=A in the following cycle.
